// File: rtl/calc_pkg.sv
// Shared key codes, FSM state type and display-select encodings for the
// keypad calculator sequencer.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } calc_state_t;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// One decimal operand built digit by digit: value <= value*10 + d using
// shift-add, with digits beyond NUM_DIGITS silently dropped.
module bcd_accumulator #(
  parameter int NUM_DIGITS = 3,
  parameter int OP_W       = 10
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_clear,
  input  logic                                i_load,
  input  logic                                i_set,
  input  logic [3:0]                          i_digit,
  output logic [OP_W-1:0]                     o_value,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     o_count
);

  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [OP_W-1:0] r_value;
  logic [CW-1:0]   r_count;
  logic [OP_W-1:0] w_next;
  logic            w_room;

  assign w_next = (r_value << 3) + (r_value << 1) + OP_W'(i_digit);
  assign w_room = r_count < CW'(NUM_DIGITS);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_set) begin
      r_value <= OP_W'(i_digit);
      r_count <= CW'(1);
    end else if (i_load && w_room) begin
      r_value <= w_next;
      r_count <= r_count + CW'(1);
    end
  end

  assign o_value = r_value;
  assign o_count = r_count;

endmodule

// File: rtl/keypad_calc_sequencer.sv
// Turns keypad strobes into operands A and B, hands them to the adder with a
// req/ack handshake and chooses what the display shows.
module keypad_calc_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int ACK_TIMEOUT = 1024,
  localparam int OP_W       = $clog2(10 ** NUM_DIGITS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_valid,
  input  logic [3:0]        i_key_code,
  input  logic              i_calc_ack,
  input  logic [OP_W:0]     i_calc_result,
  output logic [OP_W-1:0]   o_operand_a,
  output logic [OP_W-1:0]   o_operand_b,
  output logic              o_calc_req,
  output logic [OP_W:0]     o_disp_value,
  output logic [1:0]        o_disp_sel,
  output logic              o_calc_err,
  output calc_state_t       o_state
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  // Handshake: calc_req is high for every cycle in CALC; operands cannot
  // change there, and the adder's calc_ack is taken in the cycle it is high.
  calc_state_t     r_state, w_next;
  logic [OP_W:0]   r_result;
  logic [TW-1:0]   r_to_cnt;
  logic            r_err;

  logic w_digit, w_clr, w_add, w_eq;
  logic w_a_load, w_a_clear, w_a_set, w_b_load, w_b_clear;
  logic w_res_load, w_res_clear, w_timeout;
  logic [CW-1:0] w_a_count, w_b_count;

  assign w_digit = i_key_valid && is_digit(i_key_code);
  assign w_clr   = i_key_valid && (i_key_code == KEY_CLR);
  assign w_add   = i_key_valid && (i_key_code == KEY_ADD);
  assign w_eq    = i_key_valid && (i_key_code == KEY_EQ);

  always_comb begin
    w_next      = r_state;
    w_a_load    = 1'b0;
    w_a_clear   = 1'b0;
    w_a_set     = 1'b0;
    w_b_load    = 1'b0;
    w_b_clear   = 1'b0;
    w_res_load  = 1'b0;
    w_res_clear = 1'b0;
    w_timeout   = 1'b0;
    if (w_clr) begin
      w_next      = ENTER_A;
      w_a_clear   = 1'b1;
      w_b_clear   = 1'b1;
      w_res_clear = 1'b1;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_digit) begin
            w_a_load = 1'b1;
          end else if (w_add) begin
            w_next    = ENTER_B;
            w_b_clear = 1'b1;
          end
        end
        ENTER_B: begin
          if (w_digit) begin
            w_b_load = 1'b1;
          end else if (w_eq) begin
            w_next = CALC;
          end
        end
        CALC: begin
          if (i_calc_ack) begin
            w_res_load = 1'b1;
            w_next     = SHOW;
          end else if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            w_timeout   = 1'b1;
            w_next      = ENTER_A;
            w_a_clear   = 1'b1;
            w_b_clear   = 1'b1;
            w_res_clear = 1'b1;
          end
        end
        SHOW: begin
          if (w_digit) begin
            w_a_set   = 1'b1;
            w_b_clear = 1'b1;
            w_next    = ENTER_A;
          end
        end
        default: w_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ENTER_A;
      r_result <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_res_clear)     r_result <= '0;
      else if (w_res_load) r_result <= i_calc_result;
      r_to_cnt <= (r_state == CALC && w_next == CALC) ? r_to_cnt + TW'(1) : '0;
      if (w_timeout)        r_err <= 1'b1;
      else if (i_key_valid) r_err <= 1'b0;
    end
  end

  bcd_accumulator #(.NUM_DIGITS(NUM_DIGITS), .OP_W(OP_W)) u_acc_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_a_clear),
    .i_load  (w_a_load),
    .i_set   (w_a_set),
    .i_digit (i_key_code),
    .o_value (o_operand_a),
    .o_count (w_a_count)
  );

  bcd_accumulator #(.NUM_DIGITS(NUM_DIGITS), .OP_W(OP_W)) u_acc_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_b_clear),
    .i_load  (w_b_load),
    .i_set   (1'b0),
    .i_digit (i_key_code),
    .o_value (o_operand_b),
    .o_count (w_b_count)
  );

  always_comb begin
    o_disp_sel   = DISP_A;
    o_disp_value = {1'b0, o_operand_a};
    case (r_state)
      ENTER_B, CALC: begin
        o_disp_sel   = DISP_B;
        o_disp_value = {1'b0, o_operand_b};
      end
      SHOW: begin
        o_disp_sel   = DISP_RES;
        o_disp_value = r_result;
      end
      default: ;
    endcase
  end

  assign o_calc_req = (r_state == CALC);
  assign o_calc_err = r_err;
  assign o_state    = r_state;

  logic w_unused;
  assign w_unused = ^{w_a_count, w_b_count};

endmodule

// File: tb/tb_keypad_calc_sequencer.sv
// Directed bench for keypad_calc_sequencer: keystroke sequences with
// hand-computed operand, display and handshake values.
module tb_keypad_calc_sequencer;
  import calc_pkg::*;

  localparam int NUM_DIGITS  = 3;
  localparam int ACK_TIMEOUT = 1024;
  localparam int OP_W        = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_valid = 1'b0;
  logic [3:0]        key_code = 4'h0;
  logic              calc_ack = 1'b0;
  logic [OP_W:0]     calc_result = '0;
  logic [OP_W-1:0]   operand_a, operand_b;
  logic              calc_req;
  logic [OP_W:0]     disp_value;
  logic [1:0]        disp_sel;
  logic              calc_err;
  calc_state_t       state;

  int n_checks = 0;
  int n_errors = 0;

  keypad_calc_sequencer #(.NUM_DIGITS(NUM_DIGITS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_key_valid   (key_valid),
    .i_key_code    (key_code),
    .i_calc_ack    (calc_ack),
    .i_calc_result (calc_result),
    .o_operand_a   (operand_a),
    .o_operand_b   (operand_b),
    .o_calc_req    (calc_req),
    .o_disp_value  (disp_value),
    .o_disp_sel    (disp_sel),
    .o_calc_err    (calc_err),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus, called and returning on a negedge.
  task automatic step(input logic kv, input logic [3:0] code,
                      input logic ack, input logic [OP_W:0] res);
    key_valid   = kv;
    key_code    = code;
    calc_ack    = ack;
    calc_result = res;
    @(negedge clk);
    key_valid   = 1'b0;
    calc_ack    = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    step(1'b1, code, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, '0);
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'(ENTER_A));
    check("rst_a", 32'(operand_a), 0);
    check("rst_req", 32'(calc_req), 0);
    check("rst_disp", 32'(disp_value), 0);
    check("rst_err", 32'(calc_err), 0);
    rst = 1'b0;

    // 123 + 45, ack three cycles after req
    press(4'd1); press(4'd2);
    check("a_12", 32'(operand_a), 12);
    press(4'd3);
    check("a_123", 32'(operand_a), 123);
    check("disp_a", 32'(disp_value), 123);
    press(KEY_ADD);
    check("st_b", 32'(state), 32'(ENTER_B));
    check("sel_b", 32'(disp_sel), 1);
    press(4'd4); press(4'd5);
    check("b_45", 32'(operand_b), 45);
    press(KEY_EQ);
    check("req_on", 32'(calc_req), 1);
    check("sel_calc", 32'(disp_sel), 1);
    idle(2);
    check("req_held", 32'(calc_req), 1);
    step(1'b0, 4'h0, 1'b1, 11'd168);
    check("req_off", 32'(calc_req), 0);
    check("sel_res", 32'(disp_sel), 2);
    check("disp_168", 32'(disp_value), 168);
    check("a_kept", 32'(operand_a), 123);

    // digit limit, then empty B and timeout
    press(KEY_CLR);
    check("clr_a", 32'(operand_a), 0);
    check("clr_state", 32'(state), 32'(ENTER_A));
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    check("a_999", 32'(operand_a), 999);
    press(KEY_ADD); press(KEY_EQ);
    check("b_zero", 32'(operand_b), 0);
    check("req_to", 32'(calc_req), 1);
    n = 0;
    while (calc_req && n < ACK_TIMEOUT + 10) begin
      n++;
      @(negedge clk);
    end
    check("req_cycles", 32'(n), ACK_TIMEOUT);
    check("err_set", 32'(calc_err), 1);
    check("to_state", 32'(state), 32'(ENTER_A));
    check("to_a", 32'(operand_a), 0);
    check("to_b", 32'(operand_b), 0);
    press(4'd7);
    check("err_clr", 32'(calc_err), 0);
    check("a_7", 32'(operand_a), 7);

    // CLEAR and ack together: clear wins
    press(KEY_ADD); press(4'd2); press(KEY_EQ);
    check("req_clr", 32'(calc_req), 1);
    step(1'b1, KEY_CLR, 1'b1, 11'd9);
    check("ca_sel", 32'(disp_sel), 0);
    check("ca_disp", 32'(disp_value), 0);
    check("ca_req", 32'(calc_req), 0);
    check("ca_state", 32'(state), 32'(ENTER_A));

    // other key with ack: ack wins
    press(4'd1); press(KEY_ADD); press(4'd2); press(KEY_EQ);
    step(1'b1, 4'd5, 1'b1, 11'd3);
    check("ka_state", 32'(state), 32'(SHOW));
    check("ka_disp", 32'(disp_value), 3);
    check("ka_a", 32'(operand_a), 1);
    press(KEY_ADD);
    check("show_add", 32'(state), 32'(SHOW));
    press(4'd5);
    check("show_a", 32'(operand_a), 5);
    check("show_b", 32'(operand_b), 0);
    check("show_sel", 32'(disp_sel), 0);
    press(KEY_EQ); press(4'hD); press(4'hE);
    check("ign_state", 32'(state), 32'(ENTER_A));
    check("ign_a", 32'(operand_a), 5);
    step(1'b0, 4'h0, 1'b1, 11'd77);
    check("ack_idle", 32'(state), 32'(ENTER_A));
    press(4'd6);
    check("a_56", 32'(operand_a), 56);

    // reset mid-CALC
    press(KEY_ADD); press(4'd8); press(KEY_EQ);
    check("pre_rst_req", 32'(calc_req), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_req", 32'(calc_req), 0);
    check("mr_state", 32'(state), 32'(ENTER_A));
    check("mr_a", 32'(operand_a), 0);
    check("mr_b", 32'(operand_b), 0);
    check("mr_disp", 32'(disp_value), 0);
    check("mr_sel", 32'(disp_sel), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
